// File: rtl/add_one_arb_pkg.sv
// Shared types and defaults for the add_one arbiter: FSM states, channel sizing, counter width.
// The optional per-requester grant counters are enabled by ADD_ONE_ARB_STATS_EN.
package add_one_arb_pkg;

   localparam int N_REQ_DEF = 4;
   localparam int DW_DEF    = 32;
   localparam int CNT_W     = 16;

   typedef enum logic [1:0] {
      ARB  = 2'd0,
      SEND = 2'd1,
      WAIT = 2'd2,
      RESP = 2'd3
   } state_e;

endpackage

// File: rtl/add_one_arbiter_if.sv
// Requester, operand and result channels of the add_one arbiter.
// slave = arbiter view, master = environment view; grant_cnt exists only with ADD_ONE_ARB_STATS_EN.
interface add_one_arbiter_if
   import add_one_arb_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF,
   parameter int DW    = DW_DEF
) ();

   logic [N_REQ-1:0]    req_in_vld;
   logic [N_REQ*DW-1:0] req_in_data;
   logic [N_REQ-1:0]    req_in_busy;
   logic [N_REQ-1:0]    req_ret_vld;
   logic [DW-1:0]       req_ret_data;
   logic [N_REQ-1:0]    req_ret_busy;
   logic                add_one_x_out_vld;
   logic [DW-1:0]       add_one_x_out_data;
   logic                add_one_x_out_busy;
   logic                add_one_return_in_vld;
   logic [DW-1:0]       add_one_return_in_data;
   logic                add_one_return_in_busy;
`ifdef ADD_ONE_ARB_STATS_EN
   logic [N_REQ*CNT_W-1:0] grant_cnt;
`endif

   modport slave (
      input  req_in_vld, req_in_data, req_ret_busy,
             add_one_x_out_busy, add_one_return_in_vld, add_one_return_in_data,
      output req_in_busy, req_ret_vld, req_ret_data,
             add_one_x_out_vld, add_one_x_out_data, add_one_return_in_busy
`ifdef ADD_ONE_ARB_STATS_EN
      , output grant_cnt
`endif
   );

   modport master (
      output req_in_vld, req_in_data, req_ret_busy,
             add_one_x_out_busy, add_one_return_in_vld, add_one_return_in_data,
      input  req_in_busy, req_ret_vld, req_ret_data,
             add_one_x_out_vld, add_one_x_out_data, add_one_return_in_busy
`ifdef ADD_ONE_ARB_STATS_EN
      , input grant_cnt
`endif
   );

endinterface

// File: rtl/add_one_arbiter_rr_picker.sv
// Combinational round-robin picker: first asserted vld_i searching upward from ptr_i+1, wrapping.
module rr_picker
   import add_one_arb_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF,
   parameter int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] vld_i,
   input  logic [PW-1:0]    ptr_i,
   output logic [PW-1:0]    gnt_o,
   output logic             any_vld_o
);

   logic [PW-1:0] cand;

   always_comb begin
      // NOTE: every variable written here gets a default first, so no path can infer a latch.
      gnt_o     = '0;
      any_vld_o = 1'b0;
      cand      = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         cand = PW'((int'(ptr_i) + k) % N_REQ);
         if (!any_vld_o && vld_i[cand]) begin
            gnt_o     = cand;
            any_vld_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/add_one_arbiter.sv
// Round-robin arbiter sharing one add_one unit among N_REQ requesters, one transaction at a time.
// Define ADD_ONE_ARB_STATS_EN to add saturating per-requester completion counters (grant_cnt).
module add_one_arbiter
   import add_one_arb_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF,
   parameter int DW    = DW_DEF
) (
   input logic         clk,
   input logic         rst,
   add_one_arbiter_if.slave bus
);

   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   state_e        state_q, state_d;
   logic [PW-1:0] ptr_q, ptr_d;
   logic [PW-1:0] gnt_q, gnt_d;
   logic [DW-1:0] op_q, op_d;
   logic [DW-1:0] res_q, res_d;

   logic [PW-1:0]    pick;
   logic             any_vld;
   logic [N_REQ-1:0] in_busy;
   logic [N_REQ-1:0] ret_vld;
   logic             x_vld;
   logic             rin_busy;
   logic             resp_done;

   rr_picker #(.N_REQ(N_REQ), .PW(PW)) u_picker (
      .vld_i     (bus.req_in_vld),
      .ptr_i     (ptr_q),
      .gnt_o     (pick),
      .any_vld_o (any_vld)
   );

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      gnt_d     = gnt_q;
      op_d      = op_q;
      res_d     = res_q;
      in_busy   = '1;
      ret_vld   = '0;
      x_vld     = 1'b0;
      rin_busy  = 1'b1;
      resp_done = 1'b0;
      unique case (state_q)
         ARB: begin
            // Only the picked requester sees busy=0, so its vld alone completes the transfer.
            if (any_vld) begin
               in_busy[pick] = 1'b0;
               op_d          = bus.req_in_data[int'(pick)*DW +: DW];
               gnt_d         = pick;
               state_d       = SEND;
            end
         end
         SEND: begin
            x_vld = 1'b1;
            if (!bus.add_one_x_out_busy) state_d = WAIT;
         end
         WAIT: begin
            rin_busy = 1'b0;
            if (bus.add_one_return_in_vld) begin
               res_d   = bus.add_one_return_in_data;
               state_d = RESP;
            end
         end
         RESP: begin
            ret_vld[gnt_q] = 1'b1;
            if (!bus.req_ret_busy[gnt_q]) begin
               ptr_d     = gnt_q;
               resp_done = 1'b1;
               state_d   = ARB;
            end
         end
         default: state_d = ARB;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!rst) begin
         state_q <= ARB;
         ptr_q   <= PW'(N_REQ - 1);
         gnt_q   <= '0;
         op_q    <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gnt_q   <= gnt_d;
         op_q    <= op_d;
         res_q   <= res_d;
      end
   end

   assign bus.req_in_busy            = in_busy;
   assign bus.req_ret_vld            = ret_vld;
   assign bus.req_ret_data           = res_q;
   assign bus.add_one_x_out_vld      = x_vld;
   assign bus.add_one_x_out_data     = op_q;
   assign bus.add_one_return_in_busy = rin_busy;

`ifdef ADD_ONE_ARB_STATS_EN
   logic [CNT_W-1:0] cnt_q [N_REQ];

   always_ff @(posedge clk or negedge rst) begin
      // NOTE: the counter array is a handful of flops, not a RAM, so it is cleared by reset like any register.
      if (!rst) begin
         for (int i = 0; i < N_REQ; i++) cnt_q[i] <= '0;
      end else if (resp_done && (cnt_q[gnt_q] != '1)) begin
         cnt_q[gnt_q] <= cnt_q[gnt_q] + 1'b1;
      end
   end

   for (genvar i = 0; i < N_REQ; i++) begin : g_cnt
      assign bus.grant_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
   end
`endif

endmodule

// File: tb/tb_add_one_arbiter.sv
// Self-checking bench for add_one_arbiter: transaction-level reference model plus directed scenarios.
module tb_add_one_arbiter;
   import add_one_arb_pkg::*;

   localparam int N  = 4;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;

   add_one_arbiter_if #(.N_REQ(N), .DW(DW)) bus ();
   add_one_arbiter #(.N_REQ(N), .DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // ---------------- stimulus: requester sources and add_one unit ----------------
   logic [DW-1:0] src_q [N][$];
   bit            stream [N];
   logic [DW-1:0] stream_data [N];
   int            resp_delay = 0;
   int            flush_req  = 0;
   logic          x_busy     = 1'b0;
   logic [N-1:0]  ret_busy   = '0;

   assign bus.add_one_x_out_busy = x_busy;
   assign bus.req_ret_busy       = ret_busy;

   initial begin : source
      bit acc [N];
      bus.req_in_vld  = '0;
      bus.req_in_data = '0;
      for (int i = 0; i < N; i++) stream_data[i] = '0;
      forever begin
         @(negedge clk);
         for (int i = 0; i < N; i++) acc[i] = bus.req_in_vld[i] && !bus.req_in_busy[i] && rst;
         @(posedge clk);
         #1;
         for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
               if (src_q[i].size() > 0) void'(src_q[i].pop_front());
               else stream_data[i] = stream_data[i] + 1;
            end
            if (src_q[i].size() > 0) begin
               bus.req_in_vld[i]             = 1'b1;
               bus.req_in_data[i*DW +: DW]   = src_q[i][0];
            end else if (stream[i]) begin
               bus.req_in_vld[i]             = 1'b1;
               bus.req_in_data[i*DW +: DW]   = stream_data[i];
            end else begin
               bus.req_in_vld[i]             = 1'b0;
            end
         end
      end
   end

   // The add_one unit returns operand+1 resp_delay cycles after taking the operand.
   initial begin : responder
      bit            x_x, r_x, pend;
      int            left, flush_ack;
      logic [DW-1:0] xd, val;
      pend = 0; left = 0; flush_ack = 0; val = '0;
      bus.add_one_return_in_vld  = 1'b0;
      bus.add_one_return_in_data = '0;
      forever begin
         @(negedge clk);
         x_x = bus.add_one_x_out_vld && !bus.add_one_x_out_busy && rst;
         r_x = bus.add_one_return_in_vld && !bus.add_one_return_in_busy && rst;
         xd  = bus.add_one_x_out_data;
         @(posedge clk);
         #1;
         if (r_x) bus.add_one_return_in_vld = 1'b0;
         if (x_x) begin
            pend = 1; val = xd + 1; left = resp_delay;
         end
         if (pend) begin
            if (left == 0) begin
               bus.add_one_return_in_vld  = 1'b1;
               bus.add_one_return_in_data = val;
               pend = 0;
            end else left--;
         end
         if (flush_ack != flush_req) begin
            flush_ack = flush_req;
            pend = 0;
            bus.add_one_return_in_vld = 1'b0;
         end
      end
   end

   // ---------------- monitor: transfer logs for directed checks ----------------
   int            grant_log [$];
   int            acc_cyc [$];
   int            res_idx [$];
   logic [DW-1:0] res_data [$];
   int            res_cyc [$];
   int            n_res [N];

   always @(negedge clk) begin
      if (rst) begin
         for (int i = 0; i < N; i++) begin
            if (bus.req_in_vld[i] && !bus.req_in_busy[i]) begin
               grant_log.push_back(i);
               acc_cyc.push_back(cyc);
            end
            if (bus.req_ret_vld[i] && !bus.req_ret_busy[i]) begin
               res_idx.push_back(i);
               res_data.push_back(bus.req_ret_data);
               res_cyc.push_back(cyc);
               n_res[i] = n_res[i] + 1;
            end
         end
      end
   end

   task automatic clear_logs();
      grant_log.delete(); acc_cyc.delete();
      res_idx.delete(); res_data.delete(); res_cyc.delete();
      for (int i = 0; i < N; i++) n_res[i] = 0;
   endtask

   // ---------------- reference model: one outstanding transaction record ----------------
   bit            m_have;
   int            m_step;   // 0 operand pending to unit, 1 awaiting result, 2 result pending to requester
   int            m_idx;
   int            m_ptr;
   logic [DW-1:0] m_op, m_res;
`ifdef ADD_ONE_ARB_STATS_EN
   int            m_cnt [N];
`endif

   function automatic int winner(input logic [N-1:0] v, input int p);
      for (int k = 1; k <= N; k++) if (v[(p + k) % N]) return (p + k) % N;
      return -1;
   endfunction

   always @(negedge clk) begin : compare
      logic [N-1:0] e_busy, e_rvld;
      logic         e_xvld, e_rbusy;
      int           w;
      if (!rst) begin
         m_have = 0; m_step = 0; m_idx = 0; m_ptr = N - 1; m_op = '0; m_res = '0;
`ifdef ADD_ONE_ARB_STATS_EN
         for (int i = 0; i < N; i++) m_cnt[i] = 0;
`endif
         check("rst_req_in_busy", bus.req_in_busy, {N{1'b1}});
         check("rst_req_ret_vld", bus.req_ret_vld, '0);
         check("rst_x_out_vld", bus.add_one_x_out_vld, 0);
         check("rst_return_in_busy", bus.add_one_return_in_busy, 1);
         check("rst_x_out_data", bus.add_one_x_out_data, '0);
         check("rst_req_ret_data", bus.req_ret_data, '0);
      end else begin
         e_busy = '1; e_rvld = '0; e_xvld = 1'b0; e_rbusy = 1'b1; w = -1;
         if (!m_have) begin
            w = winner(bus.req_in_vld, m_ptr);
            if (w >= 0) e_busy[w] = 1'b0;
         end else if (m_step == 0) e_xvld = 1'b1;
         else if (m_step == 1) e_rbusy = 1'b0;
         else e_rvld[m_idx] = 1'b1;
         check("req_in_busy", bus.req_in_busy, e_busy);
         check("x_out_vld", bus.add_one_x_out_vld, e_xvld);
         check("return_in_busy", bus.add_one_return_in_busy, e_rbusy);
         check("req_ret_vld", bus.req_ret_vld, e_rvld);
         if (m_have && m_step == 0) check("x_out_data", bus.add_one_x_out_data, m_op);
         if (m_have && m_step == 2) check("req_ret_data", bus.req_ret_data, m_res);
`ifdef ADD_ONE_ARB_STATS_EN
         for (int i = 0; i < N; i++) check("grant_cnt", bus.grant_cnt[i*CNT_W +: CNT_W], m_cnt[i]);
`endif
         // Advance to what must hold after the coming edge.
         if (w >= 0) begin
            m_have = 1; m_step = 0; m_idx = w; m_op = bus.req_in_data[w*DW +: DW];
         end else if (m_have) begin
            if (m_step == 0 && !bus.add_one_x_out_busy) m_step = 1;
            else if (m_step == 1 && bus.add_one_return_in_vld) begin
               m_res = bus.add_one_return_in_data; m_step = 2;
            end else if (m_step == 2 && !bus.req_ret_busy[m_idx]) begin
               m_ptr = m_idx; m_have = 0;
`ifdef ADD_ONE_ARB_STATS_EN
               if (m_cnt[m_idx] < 65535) m_cnt[m_idx] = m_cnt[m_idx] + 1;
`endif
            end
         end
      end
   end

   // ---------------- directed scenarios ----------------
   task automatic do_reset();
      rst = 1'b0;
      tick(2);
      check("reset_req_in_busy", bus.req_in_busy, 4'hF);
      check("reset_req_ret_vld", bus.req_ret_vld, 4'h0);
      check("reset_x_out_vld", bus.add_one_x_out_vld, 0);
      check("reset_return_in_busy", bus.add_one_return_in_busy, 1);
      check("reset_x_out_data", bus.add_one_x_out_data, 0);
      check("reset_req_ret_data", bus.req_ret_data, 0);
      rst = 1'b1;
      clear_logs();
   endtask

   task automatic wait_grants(input string name, input int n, input int bound);
      int k = 0;
      while (grant_log.size() < n && k < bound) begin tick(1); k++; end
      check({name, "_grant_count"}, grant_log.size(), n);
   endtask

   task automatic wait_results(input string name, input int n, input int bound);
      int k = 0;
      while (res_idx.size() < n && k < bound) begin tick(1); k++; end
      check({name, "_result_count"}, res_idx.size(), n);
   endtask

   initial begin : watchdog
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      logic [DW-1:0] t2_res [8];
      int            t2_order [8];
      int            k, cnt2;
      bit            reached, late_seen;
      t2_order = '{0, 1, 2, 3, 0, 1, 2, 3};
      t2_res   = '{32'h1, 32'h101, 32'h201, 32'h301, 32'h2, 32'h102, 32'h202, 32'h302};
      for (int i = 0; i < N; i++) stream[i] = 0;
      #2;
      do_reset();

      // Single request, zero-wait unit: result 3 cycles after accept.
      src_q[0].push_back(32'h0000_0010);
      wait_results("t1", 1, 50);
      if (res_idx.size() == 1 && grant_log.size() == 1) begin
         check("t1_grant_idx", grant_log[0], 0);
         check("t1_result_idx", res_idx[0], 0);
         check("t1_result_data", res_data[0], 32'h0000_0011);
         check("t1_latency", res_cyc[0] - acc_cyc[0], 3);
      end

      // All four held valid for 8 transactions: strict rotation, 4-cycle spacing.
      do_reset();
      for (int n = 0; n < 2; n++)
         for (int i = 0; i < N; i++) src_q[i].push_back(32'h100 * i + n + 1 - 1);
      wait_results("t2", 8, 200);
      if (grant_log.size() == 8 && res_idx.size() == 8) begin
         for (int j = 0; j < 8; j++) begin
            check("t2_grant_order", grant_log[j], t2_order[j]);
            check("t2_result_data", res_data[j], t2_res[j]);
         end
         for (int j = 0; j < 7; j++) check("t2_accept_spacing", acc_cyc[j+1] - acc_cyc[j], 4);
      end

      // Back-pressured unit: operand held, nobody else granted, one result.
      clear_logs();
      x_busy = 1'b1;
      resp_delay = 3;
      src_q[2].push_back(32'h0000_0ABC);
      wait_grants("t3", 1, 50);
      src_q[0].push_back(32'h5);
      src_q[3].push_back(32'h6);
      tick(1);
      for (int j = 0; j < 5; j++) begin
         @(negedge clk);
         check("t3_x_vld_held", bus.add_one_x_out_vld, 1);
         check("t3_x_data_held", bus.add_one_x_out_data, 32'h0000_0ABC);
         check("t3_no_busy_drop", bus.req_in_busy, 4'hF);
      end
      @(posedge clk); #1;
      x_busy = 1'b0;
      wait_results("t3", 3, 100);
      resp_delay = 0;
      cnt2 = 0;
      foreach (res_idx[j]) if (res_idx[j] == 2) cnt2++;
      check("t3_req2_results", cnt2, 1);
      if (res_idx.size() == 3 && grant_log.size() == 3) begin
         check("t3_first_idx", res_idx[0], 2);
         check("t3_first_data", res_data[0], 32'h0000_0ABD);
         check("t3_next_grant", grant_log[1], 3);
         check("t3_last_grant", grant_log[2], 0);
      end

      // ptr=3 with only req1: wrap to 1; result held while its busy is high.
      do_reset();
      ret_busy = 4'b0010;
      src_q[1].push_back(32'h77);
      k = 0;
      while (!bus.req_ret_vld[1] && k < 50) begin tick(1); k++; end
      check("t4_resp_reached", bus.req_ret_vld, 4'b0010);
      src_q[0].push_back(32'h88);
      tick(1);
      for (int j = 0; j < 4; j++) begin
         @(negedge clk);
         check("t4_resp_hold_vld", bus.req_ret_vld, 4'b0010);
         check("t4_resp_hold_data", bus.req_ret_data, 32'h78);
         check("t4_no_new_grant", bus.req_in_busy, 4'hF);
      end
      check("t4_single_grant", grant_log.size(), 1);
      @(posedge clk); #1;
      ret_busy = '0;
      wait_results("t4", 2, 50);
      if (grant_log.size() == 2 && res_idx.size() == 2) begin
         check("t4_grant_wrap", grant_log[0], 1);
         check("t4_grant_next", grant_log[1], 0);
         check("t4_data_next", res_data[1], 32'h89);
      end

      // Reset during WAIT: transaction abandoned, late return ignored.
      do_reset();
      resp_delay = 6;
      src_q[3].push_back(32'h55);
      k = 0; reached = 0;
      while (!reached && k < 30) begin
         tick(1); k++;
         reached = !bus.add_one_return_in_busy;
      end
      check("t5_reached_wait", reached, 1);
      do_reset();
      late_seen = 0;
      for (int j = 0; j < 8; j++) begin
         tick(1);
         late_seen |= bus.add_one_return_in_vld;
         check("t5_return_busy", bus.add_one_return_in_busy, 1);
         check("t5_no_ret_vld", bus.req_ret_vld, 4'h0);
      end
      check("t5_late_return_presented", late_seen, 1);
      check("t5_no_result", res_idx.size(), 0);
      flush_req++;
      resp_delay = 0;
      tick(2);
      src_q[0].push_back(32'h1234);
      wait_results("t5_recover", 1, 50);
      if (res_idx.size() == 1) begin
         check("t5_recover_idx", res_idx[0], 0);
         check("t5_recover_data", res_data[0], 32'h1235);
      end

`ifdef ADD_ONE_ARB_STATS_EN
      // 70000 completions on req2 saturate its counter; others stay cleared.
      do_reset();
      stream[2] = 1;
      k = 0;
      while (n_res[2] < 70000 && k < 300000) begin tick(1); k++; end
      stream[2] = 0;
      check("t6_completions", n_res[2] >= 70000, 1);
      tick(10);
      check("t6_cnt2_saturated", bus.grant_cnt[2*CNT_W +: CNT_W], 16'hFFFF);
      check("t6_cnt0", bus.grant_cnt[0*CNT_W +: CNT_W], 16'h0);
      check("t6_cnt1", bus.grant_cnt[1*CNT_W +: CNT_W], 16'h0);
      check("t6_cnt3", bus.grant_cnt[3*CNT_W +: CNT_W], 16'h0);
`endif

      tick(3);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
